// File: rtl/sgd_b_dispatch_pkg.sv
// Shared constants and FSM state type for the SGD b-vector dispatch path.
package sgd_b_dispatch_pkg;

  localparam int SGD_NUM_OF_BANKS     = 8;
  localparam int SGD_BEAT_W           = 512;
  localparam int SGD_SAMPLES_PER_BEAT = 16;
  localparam int SGD_B_W              = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } b_state_t;

  // ceil(n / 2**sh) computed without the n + (2**sh - 1) overflow.
  function automatic logic [31:0] ceil_div_pow2(input logic [31:0] n, input int sh);
    logic [31:0] mask;
    mask = (32'd1 << sh) - 32'd1;
    return (n >> sh) + {31'd0, |(n & mask)};
  endfunction

endpackage

// File: rtl/sgd_b_serializer.sv
// Holds one 512-bit read beat and emits it as lower then upper b word,
// zeroing samples past the end of the epoch and dropping an empty upper word.
module sgd_b_serializer
  import sgd_b_dispatch_pkg::*;
#(
  parameter int NUM_OF_BANKS = SGD_NUM_OF_BANKS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SGD_BEAT_W-1:0]           in_data,
  input  logic [4:0]                      in_nvalid,
  input  logic                            almost_full,
  output logic [SGD_B_W*NUM_OF_BANKS-1:0] out_data,
  output logic                            wr_en,
  output logic                            beat_done
);

  localparam int WORD_W = SGD_B_W * NUM_OF_BANKS;

  logic [SGD_BEAT_W-1:0] masked;
  logic                  drop_upper;
  logic [WORD_W-1:0]     upper_q;
  logic                  out_vld;
  logic                  upper_vld;

  always_comb begin
    masked = '0;
    for (int k = 0; k < SGD_SAMPLES_PER_BEAT; k++) begin
      if (5'(k) < in_nvalid) masked[SGD_B_W*k +: SGD_B_W] = in_data[SGD_B_W*k +: SGD_B_W];
    end
  end

  assign drop_upper = in_nvalid <= 5'(SGD_SAMPLES_PER_BEAT / 2);
  assign wr_en      = out_vld && !almost_full;
  assign beat_done  = wr_en && !upper_vld;
  // A new beat may land in the same cycle the previous beat's final word leaves.
  assign in_ready   = !out_vld || beat_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      upper_q   <= '0;
      out_vld   <= 1'b0;
      upper_vld <= 1'b0;
    end else begin
      if (wr_en) begin
        if (upper_vld) begin
          out_data  <= upper_q;
          upper_vld <= 1'b0;
        end else begin
          out_vld <= 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        out_data  <= masked[WORD_W-1:0];
        upper_q   <= masked[2*WORD_W-1:WORD_W];
        out_vld   <= 1'b1;
        upper_vld <= !drop_upper;
      end
    end
  end

endmodule

// File: rtl/sgd_b_dispatch.sv
// Streams the b vector from memory once per epoch into the b FIFO, issuing
// beat reads with a bounded number in flight and serializing each beat.
module sgd_b_dispatch
  import sgd_b_dispatch_pkg::*;
#(
  parameter int NUM_OF_BANKS    = SGD_NUM_OF_BANKS,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [33:0]                     b_base_addr,
  input  logic [31:0]                     num_samples,
  input  logic [31:0]                     num_epochs,
  output logic                            rd_req_valid,
  input  logic                            rd_req_ready,
  output logic [33:0]                     rd_req_addr,
  input  logic                            rd_rsp_valid,
  output logic                            rd_rsp_ready,
  input  logic [SGD_BEAT_W-1:0]           rd_rsp_data,
  output logic [SGD_B_W*NUM_OF_BANKS-1:0] dispatch_axb_b_data,
  output logic                            dispatch_axb_b_wr_en,
  input  logic                            dispatch_axb_b_almost_full,
  output logic                            busy,
  output logic                            done
);

  b_state_t    state;
  logic [33:0] base_q;
  logic [31:0] ns_q, ne_q, beats;
  logic [31:0] req_beat, req_epoch, rsp_beat, rsp_epoch, outstanding;
  logic        rsp_all;
  logic        req_hs, rsp_hs, ser_ready, beat_done, last_rsp_beat;
  logic [4:0]  rsp_nvalid;

  assign beats         = ceil_div_pow2(ns_q, 4);
  assign rd_req_valid  = (state == ST_RUN) && (outstanding < 32'(MAX_OUTSTANDING));
  assign rd_req_addr   = base_q + 34'({req_beat, 6'b0});
  assign rd_rsp_ready  = (state != ST_IDLE) && ser_ready;
  assign req_hs        = rd_req_valid && rd_req_ready;
  assign rsp_hs        = rd_rsp_valid && rd_rsp_ready;
  assign last_rsp_beat = rsp_beat == beats - 32'd1;
  // Only the final beat of an epoch can be partial; a multiple of 16 fills it.
  assign rsp_nvalid    = (last_rsp_beat && ns_q[3:0] != 4'd0) ? {1'b0, ns_q[3:0]} : 5'd16;

  sgd_b_serializer #(.NUM_OF_BANKS(NUM_OF_BANKS)) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (rd_rsp_valid && (state != ST_IDLE)),
    .in_ready   (ser_ready),
    .in_data    (rd_rsp_data),
    .in_nvalid  (rsp_nvalid),
    .almost_full(dispatch_axb_b_almost_full),
    .out_data   (dispatch_axb_b_data),
    .wr_en      (dispatch_axb_b_wr_en),
    .beat_done  (beat_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      base_q      <= '0;
      ns_q        <= '0;
      ne_q        <= '0;
      req_beat    <= '0;
      req_epoch   <= '0;
      rsp_beat    <= '0;
      rsp_epoch   <= '0;
      rsp_all     <= 1'b0;
      outstanding <= '0;
    end else begin
      done <= 1'b0;
      if (req_hs && !rsp_hs)      outstanding <= outstanding + 32'd1;
      else if (rsp_hs && !req_hs) outstanding <= outstanding - 32'd1;

      if (rsp_hs) begin
        if (last_rsp_beat) begin
          rsp_beat <= '0;
          if (rsp_epoch == ne_q - 32'd1) rsp_all   <= 1'b1;
          else                           rsp_epoch <= rsp_epoch + 32'd1;
        end else begin
          rsp_beat <= rsp_beat + 32'd1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_samples != '0 && num_epochs != '0) begin
              state     <= ST_RUN;
              busy      <= 1'b1;
              base_q    <= b_base_addr;
              ns_q      <= num_samples;
              ne_q      <= num_epochs;
              req_beat  <= '0;
              req_epoch <= '0;
              rsp_beat  <= '0;
              rsp_epoch <= '0;
              rsp_all   <= 1'b0;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (req_hs) begin
            if (req_beat == beats - 32'd1) begin
              req_beat <= '0;
              if (req_epoch == ne_q - 32'd1) state <= ST_DRAIN;
              else                           req_epoch <= req_epoch + 32'd1;
            end else begin
              req_beat <= req_beat + 32'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (rsp_all && beat_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sgd_b_dispatch.sv
// Scoreboard bench for sgd_b_dispatch: a memory responder plus a sample-level
// reference model of the expected request addresses and b words.
module tb_sgd_b_dispatch;

  localparam int NB   = 8;
  localparam int MAXO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [33:0]     b_base_addr = '0;
  logic [31:0]     num_samples = '0;
  logic [31:0]     num_epochs = '0;
  logic            rd_req_valid;
  logic            rd_req_ready = 1'b0;
  logic [33:0]     rd_req_addr;
  logic            rd_rsp_valid = 1'b0;
  logic            rd_rsp_ready;
  logic [511:0]    rd_rsp_data = '0;
  logic [32*NB-1:0] b_data;
  logic            b_wr_en;
  logic            almost_full = 1'b0;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  sgd_b_dispatch #(.NUM_OF_BANKS(NB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .start                     (start),
    .b_base_addr               (b_base_addr),
    .num_samples               (num_samples),
    .num_epochs                (num_epochs),
    .rd_req_valid              (rd_req_valid),
    .rd_req_ready              (rd_req_ready),
    .rd_req_addr               (rd_req_addr),
    .rd_rsp_valid              (rd_rsp_valid),
    .rd_rsp_ready              (rd_rsp_ready),
    .rd_rsp_data               (rd_rsp_data),
    .dispatch_axb_b_data       (b_data),
    .dispatch_axb_b_wr_en      (b_wr_en),
    .dispatch_axb_b_almost_full(almost_full),
    .busy                      (busy),
    .done                      (done)
  );

  typedef struct {
    logic [33:0] addr;
    int          t;
  } pend_t;

  pend_t           pend[$];
  logic [33:0]     exp_req[$];
  logic [32*NB-1:0] exp_word[$];

  int vectors = 0, miscompares = 0, cyc = 0;
  int lat_cfg = 1, rdy_pct = 100, af_pct = 0, rsp_pct = 100;
  bit stall_arm = 0;
  int stall_left = 0;
  bit rsp_taken = 0;
  int wr_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0, inflight = 0, peak_inflight = 0;
  bit done_seen = 0;
  int done_cyc = 0;
  logic [31:0] salt = 32'h1234_5678;

  function automatic logic [31:0] mem_val(input logic [33:0] a, input int k);
    return (32'(a >> 6) * 32'h9E37_79B1) ^ (32'(k + 1) * 32'h85EB_CA6B) ^ salt;
  endfunction

  function automatic logic [511:0] beat_of(input logic [33:0] a);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = mem_val(a, k);
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not expected / did not occur", name);
  endtask

  // Reference model: sample s of an epoch lives in beat s/16, slot s%16,
  // and lands in word s/8, lane s%8; each epoch rereads the same beats.
  task automatic build_exp(input int ns, input int ne, input logic [33:0] base);
    int nbeat, nword, s;
    logic [32*NB-1:0] wd;
    nbeat = (ns + 15) / 16;
    nword = (ns + 7) / 8;
    for (int e = 0; e < ne; e++) begin
      for (int i = 0; i < nbeat; i++) exp_req.push_back(base + 34'(64 * i));
      for (int j = 0; j < nword; j++) begin
        wd = '0;
        for (int n = 0; n < NB; n++) begin
          s = 8 * j + n;
          if (s < ns) wd[32*n +: 32] = mem_val(base + 34'(64 * (s / 16)), s % 16);
        end
        exp_word.push_back(wd);
      end
    end
  endtask

  // Memory side and FIFO backpressure, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    rd_req_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    if (stall_arm && wr_cnt >= 3) begin
      stall_arm  = 0;
      stall_left = 10;
    end
    if (stall_left > 0) begin
      almost_full = 1'b1;
      stall_left--;
    end else begin
      almost_full = (int'($urandom_range(0, 99)) < af_pct);
    end
    if (!rst_n) begin
      rd_rsp_valid = 1'b0;
    end else if (!rd_rsp_valid || rsp_taken) begin
      rsp_taken = 0;
      if (pend.size() > 0 && pend[0].t <= cyc && int'($urandom_range(0, 99)) < rsp_pct) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = beat_of(pend[0].addr);
      end else begin
        rd_rsp_valid = 1'b0;
      end
    end
  end

  logic            prev_req_wait = 0, prev_rsp_hs = 0, prev_wr = 1;
  logic [33:0]     prev_addr = '0;
  logic [32*NB-1:0] prev_data = '0;

  // Monitor: samples mid-cycle, when inputs and outputs for the coming edge are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend.delete();
      inflight      = 0;
      rsp_taken     = 0;
      prev_req_wait = 0;
      prev_rsp_hs   = 0;
      prev_wr       = 1;
    end else begin
      logic rq, rs;
      rq = rd_req_valid && rd_req_ready;
      rs = rd_rsp_valid && rd_rsp_ready;
      if (prev_req_wait) begin
        check("req_hold_valid", rd_req_valid, 1);
        check("req_hold_addr", rd_req_addr, prev_addr);
      end
      if (rd_req_valid) check("req_limit", inflight < MAXO, 1);
      if (busy && exp_req.size() > 0 && inflight < MAXO) check("req_resume", rd_req_valid, 1);
      if (rq) begin
        if (exp_req.size() == 0) fail_now("req_extra");
        else check("req_addr", rd_req_addr, exp_req.pop_front());
        pend.push_back('{rd_req_addr, cyc + lat_cfg});
      end
      if (rs) begin
        if (pend.size() > 0) void'(pend.pop_front());
        rsp_taken = 1;
      end
      if (prev_rsp_hs) check("rsp_to_wr_latency", b_wr_en, !almost_full);
      if (!prev_wr && !prev_rsp_hs) check("data_hold", b_data, prev_data);
      if (b_wr_en) begin
        check("wr_while_af", almost_full, 0);
        wr_cnt++;
        if (wr_cnt == 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        if (exp_word.size() == 0) fail_now("word_extra");
        else check("word", b_data, exp_word.pop_front());
      end
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
      inflight = inflight + int'(rq) - int'(rs);
      if (inflight > peak_inflight) peak_inflight = inflight;
      prev_req_wait = rd_req_valid && !rd_req_ready;
      prev_addr     = rd_req_addr;
      prev_rsp_hs   = rs;
      prev_wr       = b_wr_en;
      prev_data     = b_data;
    end
  end

  task automatic run(input int ns, input int ne, input bit poke, input int rst_at);
    logic [33:0] base;
    bit zero;
    int s;
    base = 34'($urandom_range(0, 1 << 20)) << 6;
    salt = $urandom;
    zero = (ns == 0 || ne == 0);
    if (!zero) build_exp(ns, ne, base);
    wr_cnt = 0;
    done_seen = 0;
    peak_inflight = 0;
    @(posedge clk);
    #2;
    start = 1'b1;
    b_base_addr = base;
    num_samples = ns;
    num_epochs  = ne;
    s = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
    b_base_addr = 34'($urandom) << 6;
    num_samples = $urandom;
    num_epochs  = $urandom;
    check("busy_after_start", busy, !zero);
    for (int i = 0; i < 20000 && !done_seen; i++) begin
      @(negedge clk);
      if (rst_at > 0 && i == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_valid", rd_req_valid, 0);
        check("rst_rsp_ready", rd_rsp_ready, 0);
        check("rst_wr_en", b_wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", b_data, 0);
        exp_req.delete();
        exp_word.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        return;
      end
      start = (poke && i == 3 && busy);
    end
    start = 1'b0;
    if (!done_seen) begin
      fail_now("done_timeout");
    end else if (zero) begin
      check("done_zero_cyc", done_cyc, s + 1);
    end else begin
      check("done_after_last_wr", done_cyc, last_wr_cyc + 1);
      check("wr_count", wr_cnt, ne * ((ns + 7) / 8));
      check("words_left", exp_word.size(), 0);
      check("reqs_left", exp_req.size(), 0);
    end
    @(negedge clk);
    check("idle_after_done", busy, 0);
    check("done_single_pulse", done, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_req_valid", rd_req_valid, 0);
    check("reset_rsp_ready", rd_rsp_ready, 0);
    check("reset_wr_en", b_wr_en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_data", b_data, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Two full beats back to back, no stalls.
    lat_cfg = 1; rdy_pct = 100; af_pct = 0; rsp_pct = 100;
    run(32, 1, 0, 0);
    check("four_consecutive_words", last_wr_cyc - first_wr_cyc, 3);

    run(20, 2, 0, 0);
    run(5, 1, 0, 0);
    run(8, 1, 0, 0);
    run(9, 1, 0, 0);
    run(16, 2, 0, 0);
    run(17, 1, 0, 0);

    // Ten-cycle FIFO stall in the middle of a run.
    lat_cfg = 2; stall_arm = 1;
    run(64, 2, 0, 0);
    check("stall_taken", stall_arm, 0);

    // Slow memory: the request window must fill to the limit.
    lat_cfg = 50;
    run(1024, 1, 0, 0);
    check("peak_inflight", peak_inflight, MAXO);

    // Degenerate configurations finish immediately.
    lat_cfg = 1;
    run(0, 3, 0, 0);
    run(7, 0, 0, 0);

    for (int r = 0; r < 10; r++) begin
      lat_cfg = $urandom_range(1, 6);
      rdy_pct = $urandom_range(30, 100);
      af_pct  = $urandom_range(0, 40);
      rsp_pct = $urandom_range(40, 100);
      run($urandom_range(1, 80), $urandom_range(1, 3), r[0], 0);
    end

    // Reset mid-run, then a fresh short run.
    lat_cfg = 3; rdy_pct = 100; af_pct = 0; rsp_pct = 100;
    run(200, 2, 0, 12);
    run(16, 1, 0, 0);
    check("post_reset_words", wr_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sgd_b_dispatch.md
SGD_B_DISPATCH -- requirements
Module: sgd_b_dispatch

Interface
REQ-001 Parameter NUM_OF_BANKS, default 8, SHALL set the number of 32-bit b lanes per output word (output width 32*NUM_OF_BANKS).
REQ-002 Parameter MAX_OUTSTANDING, default 16, SHALL set the maximum number of in-flight read requests.
REQ-003 clk  in  1  sole clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse that launches a run.
REQ-006 b_base_addr  in  34  byte address of b[0], 64-byte aligned.
REQ-007 num_samples  in  32  samples per epoch.
REQ-008 num_epochs  in  32  number of epoch passes.
REQ-009 rd_req_valid / rd_req_ready  out/in  1/1  read-request handshake.
REQ-010 rd_req_addr  out  34  byte address of one 64-byte beat.
REQ-011 rd_rsp_valid / rd_rsp_ready  in/out  1/1  read-response handshake, in-order.
REQ-012 rd_rsp_data  in  512  16 b values, sample k in bits [32k+31:32k].
REQ-013 dispatch_axb_b_data  out  32*NUM_OF_BANKS  8 b values, lane n in bits [32n+31:32n].
REQ-014 dispatch_axb_b_wr_en  out  1  write strobe into the b FIFO.
REQ-015 dispatch_axb_b_almost_full  in  1  b FIFO prog_full backpressure.
REQ-016 busy / done  out  1/1  run active / one-cycle completion pulse.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; IDLE->RUN on start when num_samples!=0 and num_epochs!=0; start with either zero SHALL pulse done the next cycle and stay IDLE.
REQ-018 start while busy SHALL be ignored; config inputs SHALL be latched on the accepted start.
REQ-019 Beats per epoch B = ceil(num_samples/16); words per epoch W = ceil(num_samples/8).
REQ-020 Requests SHALL be issued at b_base_addr + 64*i, i = 0..B-1, restarting at i=0 for each epoch, num_epochs*B requests total.
REQ-021 rd_req_valid SHALL be high only when outstanding < MAX_OUTSTANDING and requests remain; addr/valid SHALL hold stable until ready.
REQ-022 Outstanding counter: +1 on request handshake, -1 on response handshake, unchanged when both occur in the same cycle.
REQ-023 RUN->DRAIN after the last request handshake; DRAIN->IDLE when last word written; done SHALL pulse in the cycle after the final wr_en.
REQ-024 A 512-bit holding register SHALL serialize each beat into lower word then upper word; rd_rsp_ready SHALL be high only when the register is empty or its last word is being written this cycle.
REQ-025 wr_en SHALL be asserted only in cycles where almost_full is low; output data SHALL be registered and hold while stalled.
REQ-026 Latency: response accepted in cycle N with almost_full low -> first wr_en in cycle N+1, second in N+2.
REQ-027 Last word of each epoch: lanes with sample index >= num_samples SHALL be zero; if num_samples mod 16 is in 1..8 the beat's upper word SHALL be dropped.
REQ-028 Exactly num_epochs*W wr_en pulses SHALL occur per run.
REQ-029 All counters SHALL be 32 bits; epoch/beat wrap SHALL be by explicit compare, never overflow.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, rd_req_valid 0, rd_rsp_ready 0, wr_en 0, busy 0, done 0, data 0, outstanding 0, holding register empty.
REQ-031 Reset mid-run SHALL abandon the run; responses for outstanding requests arriving after reset release SHALL not be produced by design (system resets memory side together).

Structure
REQ-032 NUM_OF_BANKS, beat width 512 and samples-per-beat 16 SHALL come from the shared sgd_defines constants; FSM state enum SHALL live in the shared package.
REQ-033 One sub-module, sgd_b_serializer (512->256 holding register, REQ-024/025/027), is natural; request generation stays in the top.

Verification
REQ-034 num_samples=32, num_epochs=1, no stall -> 2 requests at base, base+64; 4 wr_en in 4 consecutive cycles; done 1 cycle after last.
REQ-035 num_samples=20, num_epochs=2 -> 4 requests (base, base+64, base, base+64); 6 words; word 3 and 6 lanes 4..7 zero.
REQ-036 num_samples=5 -> 1 request, 1 wr_en, lanes 5..7 zero, upper half dropped.
REQ-037 almost_full held high 10 cycles mid-run -> no wr_en during stall, data stable, no word lost or duplicated.
REQ-038 rd_rsp delayed 50 cycles, num_samples=1024 -> rd_req_valid drops after 16 in-flight; resumes on first response.
REQ-039 rst_n asserted mid-run, then new start with num_samples=16 -> all outputs reset immediately; new run yields exactly 2 words, done pulse.
